spi_flash_slave: RTL and testbench
==================================

# spi_flash_slave

Synchronous SPI flash responder on the `spi_sck`/`spi_ss`/`spi_mosi`/`spi_miso` pins of the XIP SPI master, the stage directly downstream of it. Decodes the 64-bit frame the master emits (8-bit read command, 24-bit address, 32 data clocks), fetches one 32-bit word from a backing flash memory port, and shifts it back on `spi_miso`. SPI mode 0 only. All pins are sampled in the `clock` domain, since the master generates them from that clock.

## Interface
- `CMD_READ`, 8'h03, only command opcode served.
- `SS_BIT`, 0, index of `spi_ss` bit that selects this device (active-low).
- `SS_NUM`, 8, width of `spi_ss`.
- `clock  input  1  system clock; all logic on rising edge.`
- `reset  input  1  asynchronous, active-low reset.`
- `spi_sck  input  1  SPI clock from master, idle low.`
- `spi_ss  input  SS_NUM  slave selects, active-low; only spi_ss[SS_BIT] used.`
- `spi_mosi  input  1  master data, MSB first.`
- `spi_miso  output  1  slave data.`
- `mem_req  output  1  fetch request; held until accepted.`
- `mem_addr  output  24  word-aligned fetch address {addr[23:2],2'b00}.`
- `mem_ready  input  1  fetch complete; mem_rdata valid this cycle.`
- `mem_rdata  input  32  little-endian word (byte 0 = bits 7:0).`
- `underrun  output  1  one-cycle pulse: data not ready at first data bit.`

## Operation
- Edge detect: `sck_q` registers `spi_sck`. Rise = `~sck_q & spi_sck`; fall = `sck_q & ~spi_sck`. `sel` = `~spi_ss[SS_BIT]`.
- Bit counter `cnt` (7 bits) increments on each rise while `sel`. It clears whenever `sel` is 0.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE -> CMD on `sel`.
  - CMD: shift `spi_mosi` into `cmd` on each rise. After the 8th rise, go to ADDR if `cmd == CMD_READ`, else IGNORE.
  - ADDR: shift 24 bits into `addr` on rises 9..32. The cycle after rise 32, raise `mem_req` with `mem_addr` = `{addr[23:2],2'b00}` and enter DATA.
  - DATA: capture `mem_rdata` into `word` on the first cycle with `mem_req & mem_ready`, then drop `mem_req` next cycle.
    - Load the 32-bit shifter `tx` with bytes in the order `addr[1:0]`, +1, +2, +3, wrapping mod 4 within the word. Each byte is MSB first.
    - On each fall after rise 32, `spi_miso` advances to the next `tx` bit.
    - After 32 data bits (rise 64), `spi_miso` = 0 until `sel` drops.
  - IGNORE: `spi_miso` = 0. Stay until `sel` drops.
  - Any state -> IDLE when `sel` = 0; `cmd`, `addr`, `cnt`, and `tx` are discarded.
- `mem_req` handshake: once raised, it stays high with stable `mem_addr` until `mem_ready`, even if `sel` drops (abort). The returned data is discarded when aborted.
- Underrun: if no `mem_ready` has been seen by the fall following rise 32, pulse `underrun` for 1 cycle, then drive `spi_miso` = 0 for the whole data phase. A late `mem_ready` is consumed and discarded.
- `spi_miso` = 0 whenever not in DATA with valid `tx`.

## Timing
- Reset (async, `reset` = 0): state IDLE, `spi_miso` = 0, `mem_req` = 0, `mem_addr` = 0, `underrun` = 0, `sck_q` = 0, counters 0.
- Sampling: MOSI bit is taken from `spi_mosi` in the cycle where rise is detected, i.e. the first cycle with `spi_sck` = 1.
- Output: `spi_miso` changes exactly 1 clock after the first cycle with `spi_sck` = 0 following a high phase. It is stable before the next rising sck when the sck half-period is ≥ 2 clocks (the master's minimum, divider = 1).
- Fetch window: `mem_req` is asserted 1 clock after rise 32. `mem_ready` must arrive no later than the cycle of the following fall, which is ≥ 1 clock later at minimum half-period. The memory port must be single-cycle for the fastest divider.
- `sel` deassert and a sck edge in the same cycle: deselect wins; the edge is ignored.
- `sel` re-asserted the cycle after deassert: a new frame starts in CMD with `cnt` = 0. An outstanding `mem_req` still completes and is discarded.

## Test plan
- Aligned read: mem word 32'h44332211 at 0x000100, frame 0x03_000100, half-period 2 clocks -> `mem_addr` = 0x000100, miso bits 32..63 = 0x11223344 MSB-first per byte, `underrun` never pulses.
- Unaligned wrap: same word, address 0x000102 -> miso data = 0x33441122.
- Bad opcode 0x0B -> `mem_req` never asserts, miso = 0 for all 64 bits, state returns to IDLE on ss high.
- Abort: ss deasserts 2 clocks after `mem_req` rises, `mem_ready` delayed 5 clocks -> `mem_req` holds for 5 clocks then drops; the next frame at 0x000200 returns the correct word.
- Underrun: `mem_ready` delayed 6 clocks at half-period 2 -> `underrun` pulses once at the first data fall, miso = 0 for all 32 data bits.
- Reset mid-DATA (bit 40): `reset` low for 1 cycle -> `spi_miso` = 0 and `mem_req` = 0 immediately; the next full frame reads correctly.

Source files
------------

// File: rtl/spi_flash_slave.sv
// SPI mode-0 flash read responder: decodes a 03h read frame, fetches one word
// from the memory port and shifts it back on MISO with byte-wrap ordering.
module spi_flash_slave #(
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter int          SS_BIT   = 0,
    parameter int          SS_NUM   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic [SS_NUM-1:0] spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_req,
    output logic [23:0]       mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              underrun
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } state_t;

    state_t      state_q;
    logic        sck_q;
    logic [6:0]  cnt_q;
    logic [6:0]  cmd_q;
    logic [22:0] addr_q;
    logic [31:0] word_q;
    logic [31:0] tx_q;
    logic        have_q;
    logic        live_q;
    logic        txv_q;
    logic        miso_q;
    logic        req_q;
    logic [23:0] maddr_q;
    logic        underrun_q;

    logic        sel_s;
    logic        rise_s;
    logic        fall_s;
    logic        ack_s;
    logic        avail_s;
    logic [31:0] src_s;
    logic        ss_unused_s;

    // Reorders a little-endian word into transmit order starting at byte off.
    function automatic logic [31:0] order_bytes(input logic [31:0] w, input logic [1:0] off);
        logic [31:0] r;
        logic [1:0]  idx;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            idx = off + 2'(i);
            r[31 - 8*i -: 8] = w[8*idx +: 8];
        end
        return r;
    endfunction

    // Pin edge detection and fetch-data availability for the first data fall.
    always_comb begin
        sel_s   = ~spi_ss[SS_BIT];
        rise_s  = ~sck_q & spi_sck;
        fall_s  = sck_q & ~spi_sck;
        ack_s   = req_q & mem_ready;
        avail_s = have_q | (ack_s & live_q);
        if (have_q) begin
            src_s = word_q;
        end else begin
            src_s = order_bytes(mem_rdata, addr_q[1:0]);
        end
    end

    // Frame decoder, fetch handshake and MISO shifter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sck_q      <= 1'b0;
            cnt_q      <= 7'd0;
            cmd_q      <= 7'd0;
            addr_q     <= 23'd0;
            word_q     <= 32'd0;
            tx_q       <= 32'd0;
            have_q     <= 1'b0;
            live_q     <= 1'b0;
            txv_q      <= 1'b0;
            miso_q     <= 1'b0;
            req_q      <= 1'b0;
            maddr_q    <= 24'd0;
            underrun_q <= 1'b0;
        end else begin
            sck_q      <= spi_sck;
            underrun_q <= 1'b0;

            // The handshake completes even after an abort; only live data is kept.
            if (ack_s) begin
                req_q  <= 1'b0;
                live_q <= 1'b0;
                if (live_q) begin
                    word_q <= order_bytes(mem_rdata, addr_q[1:0]);
                    have_q <= 1'b1;
                end
            end

            if (!sel_s) begin
                state_q <= IDLE;
                cnt_q   <= 7'd0;
                cmd_q   <= 7'd0;
                addr_q  <= 23'd0;
                tx_q    <= 32'd0;
                txv_q   <= 1'b0;
                miso_q  <= 1'b0;
                have_q  <= 1'b0;
                live_q  <= 1'b0;
            end else begin
                if (rise_s && cnt_q != 7'h7f) begin
                    cnt_q <= cnt_q + 7'd1;
                end
                case (state_q)
                    IDLE, CMD: begin
                        state_q <= CMD;
                        if (rise_s) begin
                            cmd_q <= {cmd_q[5:0], spi_mosi};
                            if (cnt_q == 7'd7) begin
                                state_q <= ({cmd_q, spi_mosi} == CMD_READ) ? ADDR : IGNORE;
                            end
                        end
                    end
                    ADDR: begin
                        if (rise_s) begin
                            addr_q <= {addr_q[21:0], spi_mosi};
                            if (cnt_q == 7'd31) begin
                                state_q <= DATA;
                                req_q   <= 1'b1;
                                live_q  <= 1'b1;
                                have_q  <= 1'b0;
                                maddr_q <= {addr_q[22:1], 2'b00};
                            end
                        end
                    end
                    DATA: begin
                        if (fall_s) begin
                            if (cnt_q == 7'd32) begin
                                if (avail_s) begin
                                    txv_q  <= 1'b1;
                                    miso_q <= src_s[31];
                                    tx_q   <= {src_s[30:0], 1'b0};
                                end else begin
                                    underrun_q <= 1'b1;
                                    txv_q      <= 1'b0;
                                    miso_q     <= 1'b0;
                                    live_q     <= 1'b0;
                                end
                            end else if (cnt_q < 7'd64 && txv_q) begin
                                miso_q <= tx_q[31];
                                tx_q   <= {tx_q[30:0], 1'b0};
                            end else begin
                                miso_q <= 1'b0;
                                txv_q  <= 1'b0;
                            end
                        end
                    end
                    IGNORE: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ss_unused_s = ^spi_ss;
    assign spi_miso    = miso_q;
    assign mem_req     = req_q;
    assign mem_addr    = maddr_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_flash_slave.sv
// Randomised bench for spi_flash_slave: drives SPI frames, serves the memory
// port from a word array and compares MISO data against a byte-order model.
module tb_spi_flash_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic        spi_sck;
    logic [7:0]  spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        underrun;

    int checks   = 0;
    int failures = 0;

    int          mem_delay   = 0;
    int          req_age     = 0;
    int          req_hi      = 0;
    int          req_rises   = 0;
    int          urun_cnt    = 0;
    int          addr_moves  = 0;
    logic        prev_req    = 1'b0;
    logic [23:0] prev_addr   = 24'd0;
    logic [23:0] last_req_addr = 24'd0;
    logic [31:0] mem_model [logic [23:0]];

    spi_flash_slave dut (
        .clock     (clock),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .underrun  (underrun)
    );

    always #5 clock = ~clock;

    // Memory responder: answers a request mem_delay cycles after it rises.
    always @(negedge clock) begin
        if (mem_ready) begin
            mem_ready = 1'b0;
            req_age   = 0;
        end else if (mem_req) begin
            if (req_age >= mem_delay) begin
                mem_ready = 1'b1;
                mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hDEADBEEF;
            end
            req_age++;
        end else begin
            req_age = 0;
        end
        if (!mem_ready) mem_rdata = $urandom;
        if (mem_req) req_hi++;
        if (mem_req && !prev_req) begin
            req_rises++;
            last_req_addr = mem_addr;
        end
        if (mem_req && prev_req && mem_addr !== prev_addr) addr_moves++;
        if (underrun) urun_cnt++;
        prev_req  = mem_req;
        prev_addr = mem_addr;
    end

    // Expected data stream: bytes from the addressed offset upward, wrapping in the word.
    function automatic logic [31:0] exp_stream(input logic [31:0] w, input logic [23:0] a);
        logic [31:0] r;
        int off;
        r   = 32'd0;
        off = int'(a % 24'd4);
        for (int i = 0; i < 4; i++) r = (r << 8) | ((w >> (8 * ((off + i) % 4))) & 32'hFF);
        return r;
    endfunction

    task automatic clear_stats();
        req_hi     = 0;
        req_rises  = 0;
        urun_cnt   = 0;
        addr_moves = 0;
    endtask

    // Drives nbits sck pulses of a frame; records MISO as seen at each rising sck.
    task automatic run_frame(input logic [7:0] cmd, input logic [23:0] addr, input int h,
                             input int nbits, input bit release_ss, input int gap,
                             output logic [63:0] bits);
        logic [31:0] hdr;
        hdr  = {cmd, addr};
        bits = 64'd0;
        @(negedge clock);
        spi_ss[0] = 1'b0;
        spi_sck   = 1'b0;
        repeat (h) @(negedge clock);
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = (b < 32) ? hdr[31 - b] : 1'b0;
            spi_sck  = 1'b1;
            bits[63 - b] = spi_miso;
            repeat (h) @(negedge clock);
            spi_sck = 1'b0;
            repeat (h) @(negedge clock);
        end
        if (release_ss) begin
            spi_ss[0] = 1'b1;
            repeat (gap) @(negedge clock);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 24'd0) begin failures++; $display("FAIL reset_addr: got %h expected 000000", mem_addr); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_aligned();
        logic [63:0] bits;
        mem_model[24'h000100] = 32'h44332211;
        mem_delay = 0;
        clear_stats();
        run_frame(8'h03, 24'h000100, 2, 64, 1'b1, 4, bits);
        checks++; if (bits[31:0] !== 32'h11223344) begin failures++; $display("FAIL aligned_data: got %h expected 11223344", bits[31:0]); end
        checks++; if (bits[63:32] !== 32'd0) begin failures++; $display("FAIL aligned_hdr_miso: got %h expected 00000000", bits[63:32]); end
        checks++; if (req_rises !== 1) begin failures++; $display("FAIL aligned_req_count: got %0d expected 1", req_rises); end
        checks++; if (last_req_addr !== 24'h000100) begin failures++; $display("FAIL aligned_addr: got %h expected 000100", last_req_addr); end
        checks++; if (urun_cnt !== 0) begin failures++; $display("FAIL aligned_underrun: got %0d expected 0", urun_cnt); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL aligned_req_drop: got %b expected 0", mem_req); end
    endtask

    task automatic test_unaligned();
        logic [63:0] bits;
        mem_delay = 1;
        clear_stats();
        run_frame(8'h03, 24'h000102, 2, 64, 1'b1, 4, bits);
        checks++; if (bits[31:0] !== 32'h33441122) begin failures++; $display("FAIL unaligned_data: got %h expected 33441122", bits[31:0]); end
        checks++; if (last_req_addr !== 24'h000100) begin failures++; $display("FAIL unaligned_addr: got %h expected 000100", last_req_addr); end
        checks++; if (addr_moves !== 0) begin failures++; $display("FAIL unaligned_addr_stable: got %0d expected 0", addr_moves); end
    endtask

    task automatic test_bad_opcode();
        logic [63:0] bits;
        mem_delay = 0;
        clear_stats();
        run_frame(8'h0B, 24'($urandom), 2, 64, 1'b1, 4, bits);
        checks++; if (req_rises !== 0) begin failures++; $display("FAIL badop_req: got %0d expected 0", req_rises); end
        checks++; if (bits !== 64'd0) begin failures++; $display("FAIL badop_miso: got %h expected 0", bits); end
    endtask

    task automatic test_abort();
        logic [63:0] bits;
        logic [31:0] w;
        w = $urandom;
        mem_model[24'h000200] = w;
        mem_delay = 5;
        clear_stats();
        run_frame(8'h03, 24'h000300, 2, 31, 1'b0, 0, bits);
        @(negedge clock);
        spi_mosi = 1'b0;
        spi_sck  = 1'b1;
        repeat (3) @(negedge clock);
        spi_ss[0] = 1'b1;
        @(negedge clock);
        spi_sck = 1'b0;
        repeat (12) @(negedge clock);
        #1;
        checks++; if (req_rises !== 1) begin failures++; $display("FAIL abort_req_count: got %0d expected 1", req_rises); end
        checks++; if (req_hi !== 6) begin failures++; $display("FAIL abort_req_hold: got %0d cycles expected 6", req_hi); end
        checks++; if (last_req_addr !== 24'h000300) begin failures++; $display("FAIL abort_addr: got %h expected 000300", last_req_addr); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL abort_req_drop: got %b expected 0", mem_req); end
        checks++; if (urun_cnt !== 0) begin failures++; $display("FAIL abort_underrun: got %0d expected 0", urun_cnt); end
        mem_delay = 0;
        run_frame(8'h03, 24'h000200, 2, 64, 1'b1, 4, bits);
        checks++; if (bits[31:0] !== exp_stream(w, 24'h000200)) begin failures++; $display("FAIL abort_next_data: got %h expected %h", bits[31:0], exp_stream(w, 24'h000200)); end
    endtask

    task automatic test_underrun();
        logic [63:0] bits;
        logic [23:0] a;
        a = 24'($urandom);
        mem_model[{a[23:2], 2'b00}] = $urandom;
        mem_delay = 6;
        clear_stats();
        run_frame(8'h03, a, 2, 64, 1'b1, 4, bits);
        checks++; if (urun_cnt !== 1) begin failures++; $display("FAIL underrun_pulses: got %0d expected 1", urun_cnt); end
        checks++; if (bits !== 64'd0) begin failures++; $display("FAIL underrun_miso: got %h expected 0", bits); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL underrun_req_drop: got %b expected 0", mem_req); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] bits;
        logic [23:0] a;
        logic [31:0] w;
        mem_delay = 0;
        run_frame(8'h03, 24'h000100, 2, 40, 1'b0, 0, bits);
        reset = 1'b0;
        #1;
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL resetmid_miso: got %b expected 0", spi_miso); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL resetmid_req: got %b expected 0", mem_req); end
        @(negedge clock);
        reset     = 1'b1;
        spi_ss[0] = 1'b1;
        spi_sck   = 1'b0;
        repeat (3) @(negedge clock);
        a = 24'($urandom);
        w = $urandom;
        mem_model[{a[23:2], 2'b00}] = w;
        run_frame(8'h03, a, 2, 64, 1'b1, 4, bits);
        checks++; if (bits[31:0] !== exp_stream(w, a)) begin failures++; $display("FAIL resetmid_next_data: got %h expected %h", bits[31:0], exp_stream(w, a)); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] b0;
        logic [63:0] b1;
        logic [23:0] a0;
        logic [23:0] a1;
        logic [31:0] w0;
        logic [31:0] w1;
        a0 = 24'($urandom);
        a1 = {a0[23:2] + 22'd1, 2'($urandom)};
        w0 = $urandom;
        w1 = $urandom;
        mem_model[{a0[23:2], 2'b00}] = w0;
        mem_model[{a1[23:2], 2'b00}] = w1;
        mem_delay = 1;
        clear_stats();
        run_frame(8'h03, a0, 2, 64, 1'b1, 0, b0);
        run_frame(8'h03, a1, 2, 64, 1'b1, 4, b1);
        checks++; if (b0[31:0] !== exp_stream(w0, a0)) begin failures++; $display("FAIL b2b_first: got %h expected %h", b0[31:0], exp_stream(w0, a0)); end
        checks++; if (b1[31:0] !== exp_stream(w1, a1)) begin failures++; $display("FAIL b2b_second: got %h expected %h", b1[31:0], exp_stream(w1, a1)); end
        checks++; if (req_rises !== 2) begin failures++; $display("FAIL b2b_req_count: got %0d expected 2", req_rises); end
    endtask

    task automatic test_random();
        logic [63:0] bits;
        logic [23:0] a;
        logic [31:0] w;
        logic [7:0]  c;
        logic [31:0] exp_data;
        int          h;
        bit          is_read;
        for (int n = 0; n < 10; n++) begin
            h = $urandom_range(2, 4);
            mem_delay = $urandom_range(0, h - 1);
            a = 24'($urandom);
            w = $urandom;
            mem_model[{a[23:2], 2'b00}] = w;
            is_read = ($urandom_range(0, 3) != 0);
            if (is_read) begin
                c = 8'h03;
            end else begin
                c = 8'($urandom);
                if (c == 8'h03) c = 8'hFF;
            end
            exp_data = is_read ? exp_stream(w, a) : 32'd0;
            clear_stats();
            run_frame(c, a, h, 64, 1'b1, 3, bits);
            checks++; if (bits[31:0] !== exp_data) begin failures++; $display("FAIL rand_data[%0d]: got %h expected %h", n, bits[31:0], exp_data); end
            checks++; if (req_rises !== int'(is_read)) begin failures++; $display("FAIL rand_req_count[%0d]: got %0d expected %0d", n, req_rises, int'(is_read)); end
            if (is_read) begin
                checks++; if (last_req_addr !== {a[23:2], 2'b00}) begin failures++; $display("FAIL rand_addr[%0d]: got %h expected %h", n, last_req_addr, {a[23:2], 2'b00}); end
            end
            checks++; if (urun_cnt !== 0) begin failures++; $display("FAIL rand_underrun[%0d]: got %0d expected 0", n, urun_cnt); end
        end
    endtask

    initial begin
        reset     = 1'b0;
        spi_sck   = 1'b0;
        spi_ss    = 8'hFF;
        spi_mosi  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        test_reset();
        test_aligned();
        test_unaligned();
        test_bad_opcode();
        test_abort();
        test_underrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
